// File: rtl/calib_pkg.sv
// Shared types and constants for the ADC calibration parameter bank.
package calib_pkg;

  typedef logic [31:0] float32_t;

  localparam logic SEL_GAIN   = 1'b0;
  localparam logic SEL_OFFSET = 1'b1;

  typedef enum logic {IDLE, SWEEP} state_e;

  // Float32 constants: 1.1920929e-6, -10.0, 1.5258789e-4, -5.0
  localparam float32_t GAIN_DEFAULT   = 32'h35a0_0000;
  localparam float32_t OFFSET_DEFAULT = 32'hc120_0000;
  localparam float32_t GAIN_ALT       = 32'h3920_0000;
  localparam float32_t OFFSET_ALT     = 32'hc0a0_0000;

endpackage

// File: rtl/calib_axis_sweeper.sv
// Sweep sequencer: walks the channel index over AXI-Stream and coalesces
// commits that arrive mid-sweep into a single follow-on reload.
module calib_axis_sweeper
  import calib_pkg::*;
#(
  parameter int unsigned N_CH = 10,
  parameter int unsigned CH_W = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_commit,
  input  logic            i_tready,
  output logic            o_load,
  output logic            o_tvalid,
  output logic [CH_W-1:0] o_idx,
  output logic            o_tlast,
  output logic            o_busy
);

  state_e          r_state, w_state_d;
  logic [CH_W-1:0] r_idx, w_idx_d;
  logic            r_pending, w_pending_d;
  logic            w_last;
  logic            w_accept;

  assign w_last   = (r_idx == CH_W'(N_CH - 1));
  assign w_accept = (r_state == SWEEP) & i_tready;

  always_comb begin
    w_state_d   = r_state;
    w_idx_d     = r_idx;
    w_pending_d = r_pending;
    o_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_commit) begin
          o_load    = 1'b1;
          w_idx_d   = '0;
          w_state_d = SWEEP;
        end
      end
      SWEEP: begin
        if (i_commit) w_pending_d = 1'b1;
        if (w_accept) begin
          if (w_last) begin
            // A commit landing on the final beat counts as pending.
            if (r_pending | i_commit) begin
              o_load      = 1'b1;
              w_idx_d     = '0;
              w_pending_d = 1'b0;
            end else begin
              w_state_d = IDLE;
            end
          end else begin
            w_idx_d = r_idx + CH_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= SWEEP;
      r_idx     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_idx     <= w_idx_d;
      r_pending <= w_pending_d;
    end
  end

  assign o_tvalid = (r_state == SWEEP);
  assign o_idx    = r_idx;
  assign o_tlast  = w_last;
  assign o_busy   = (r_state == SWEEP) | r_pending;

endmodule

// File: rtl/calib_param_bank.sv
// Per-channel float32 gain/offset bank: CPU writes a shadow copy, commit
// snapshots it into the active copy, which is streamed and exported flat.
module calib_param_bank
  import calib_pkg::*;
#(
  parameter int unsigned N_CH       = 10,
  parameter int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter float32_t    DEF_GAIN   = GAIN_DEFAULT,
  parameter float32_t    DEF_OFFSET = OFFSET_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [CH_W:0]     i_wr_addr,
  input  logic [31:0]       i_wr_data,
  input  logic              i_commit,
  input  logic [CH_W:0]     i_rd_addr,
  output logic [31:0]       o_rd_data,
  output logic [63:0]       m_axis_tdata,
  output logic [CH_W-1:0]   m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [N_CH*32-1:0] o_gain_flat,
  output logic [N_CH*32-1:0] o_offset_flat,
  output logic              o_busy,
  output logic [15:0]       o_commit_cnt
);

  float32_t r_sh_gain  [N_CH];
  float32_t r_sh_off   [N_CH];
  float32_t w_sh_gain_d[N_CH];
  float32_t w_sh_off_d [N_CH];
  float32_t r_act_gain [N_CH];
  float32_t r_act_off  [N_CH];

  logic [31:0]     r_rd_data;
  logic [15:0]     r_commit_cnt;
  logic [CH_W-1:0] w_wr_ch, w_rd_ch, w_idx;
  logic            w_wr_ok, w_rd_ok, w_load;

  assign w_wr_ch = i_wr_addr[CH_W:1];
  assign w_rd_ch = i_rd_addr[CH_W:1];
  assign w_wr_ok = (32'(w_wr_ch) < N_CH);
  assign w_rd_ok = (32'(w_rd_ch) < N_CH);

  calib_axis_sweeper #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_sweeper (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_commit (i_commit),
    .i_tready (m_axis_tready),
    .o_load   (w_load),
    .o_tvalid (m_axis_tvalid),
    .o_idx    (w_idx),
    .o_tlast  (m_axis_tlast),
    .o_busy   (o_busy)
  );

  // Commit copies from this next-state so a same-cycle write is included.
  always_comb begin
    w_sh_gain_d = r_sh_gain;
    w_sh_off_d  = r_sh_off;
    if (i_wr_en && w_wr_ok) begin
      if (i_wr_addr[0] == SEL_GAIN) w_sh_gain_d[w_wr_ch] = i_wr_data;
      else                          w_sh_off_d[w_wr_ch]  = i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        r_sh_gain[k]  <= DEF_GAIN;
        r_sh_off[k]   <= DEF_OFFSET;
        r_act_gain[k] <= DEF_GAIN;
        r_act_off[k]  <= DEF_OFFSET;
      end
      r_rd_data    <= '0;
      r_commit_cnt <= '0;
    end else begin
      r_sh_gain <= w_sh_gain_d;
      r_sh_off  <= w_sh_off_d;
      if (w_load) begin
        r_act_gain   <= w_sh_gain_d;
        r_act_off    <= w_sh_off_d;
        r_commit_cnt <= r_commit_cnt + 16'd1;
      end
      if (!w_rd_ok)                      r_rd_data <= '0;
      else if (i_rd_addr[0] == SEL_GAIN) r_rd_data <= r_sh_gain[w_rd_ch];
      else                               r_rd_data <= r_sh_off[w_rd_ch];
    end
  end

  for (genvar k = 0; k < int'(N_CH); k++) begin : g_flat
    assign o_gain_flat[32*k +: 32]   = r_act_gain[k];
    assign o_offset_flat[32*k +: 32] = r_act_off[k];
  end

  assign m_axis_tdata = {r_act_gain[w_idx], r_act_off[w_idx]};
  assign m_axis_tuser = w_idx;
  assign o_rd_data    = r_rd_data;
  assign o_commit_cnt = r_commit_cnt;

endmodule
